// File: rtl/ex_alu_arbiter_pkg.sv
// ex_alu_arbiter_pkg: shared definitions for the EX-stage ALU arbiter slice.
// Holds the ALU op encodings (0000..1011), the arbiter FSM state type,
// the requester count and a legality helper for alu_op.
package ex_alu_arbiter_pkg;

  localparam int unsigned NREQ = 2;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SEQ  = 4'b1010;
  localparam logic [3:0] ALU_SNE  = 4'b1011;
  localparam logic [3:0] ALU_OP_MAX = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic alu_op_illegal(input logic [3:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/ex_alu_arbiter_if.sv
// ex_alu_arbiter_if: request/response bundle between the two requesters and
// the shared-ALU arbiter.
//   req_*  : per-port request (valid/ready handshake), port p in slice p
//   resp_* : held response, resp_valid one-hot to the owning port
// Modports: master = requester side, slave = arbiter side.
interface ex_alu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_rs1;
  logic [2*XLEN-1:0] req_rs2;
  logic [2*XLEN-1:0] req_imm;
  logic [1:0]        req_alu_src;
  logic [7:0]        req_alu_op;
  logic [2*TAGW-1:0] req_tag;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              resp_ovf;
  logic              resp_illegal;
  logic [TAGW-1:0]   resp_tag;

  modport master (
    output req_valid, req_rs1, req_rs2, req_imm, req_alu_src, req_alu_op,
           req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_ovf, resp_illegal, resp_tag
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_imm, req_alu_src, req_alu_op,
           req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_ovf, resp_illegal, resp_tag
  );
endinterface

// File: rtl/ex_alu_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req   : request vector
//   last  : index of the port granted most recently
//   grant : one-hot (or zero) grant; on contention the port != last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/ex_alu_arbiter.sv
// ex_alu_arbiter: shares one combinational EX-stage ALU between the main
// pipeline (port 0) and the branch/address unit (port 1).
//   clk, rst        : clock, asynchronous active-high reset
//   bus             : request/response bundle (slave side)
//   alu_*_o         : operands/op to the ALU, held while busy, zero when idle
//   alu_result_i,
//   alu_overflow_i  : ALU results, captured at the end of ISSUE
//   ovf_sticky      : set by any overflowing response, cleared by ovf_clr
//   busy            : FSM not in IDLE
module ex_alu_arbiter
  import ex_alu_arbiter_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  ex_alu_arbiter_if.slave bus,
  output logic [XLEN-1:0] alu_rs1_o,
  output logic [XLEN-1:0] alu_rs2_o,
  output logic [XLEN-1:0] alu_imm_o,
  output logic            alu_src_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_overflow_i,
  output logic            ovf_sticky,
  input  logic            ovf_clr,
  output logic            busy
);

  state_t state, state_nxt;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] req_ready_c;
  logic [NREQ-1:0] resp_valid_c;
  logic            accept;
  logic            sel;

  logic            owner;
  logic            last_grant;
  logic [XLEN-1:0] op_rs1, op_rs2, op_imm;
  logic            op_src;
  logic [3:0]      op_alu_op;
  logic [TAGW-1:0] op_tag;

  logic [XLEN-1:0] resp_data_q;
  logic            resp_ovf_q;
  logic            resp_illegal_q;
  logic [TAGW-1:0] resp_tag_q;
  logic            sticky_q;

  rr_arb2 u_rr_arb2 (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  assign sel    = req_ready_c[1];
  assign accept = |(bus.req_valid & req_ready_c);

  always_comb begin
    state_nxt    = state;
    req_ready_c  = '0;
    resp_valid_c = '0;
    unique case (state)
      IDLE: begin
        // Gated by rst so every output reads zero while reset is held.
        req_ready_c = rst ? '0 : grant;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        resp_valid_c = owner ? 2'b10 : 2'b01;
        if (bus.resp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_rs1     <= '0;
      op_rs2     <= '0;
      op_imm     <= '0;
      op_src     <= 1'b0;
      op_alu_op  <= '0;
      op_tag     <= '0;
    end else if (state == IDLE && accept) begin
      owner      <= sel;
      last_grant <= sel;
      op_rs1     <= sel ? bus.req_rs1[XLEN +: XLEN] : bus.req_rs1[0 +: XLEN];
      op_rs2     <= sel ? bus.req_rs2[XLEN +: XLEN] : bus.req_rs2[0 +: XLEN];
      op_imm     <= sel ? bus.req_imm[XLEN +: XLEN] : bus.req_imm[0 +: XLEN];
      op_src     <= bus.req_alu_src[sel];
      op_alu_op  <= sel ? bus.req_alu_op[4 +: 4] : bus.req_alu_op[0 +: 4];
      op_tag     <= sel ? bus.req_tag[TAGW +: TAGW] : bus.req_tag[0 +: TAGW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_q    <= '0;
      resp_ovf_q     <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_tag_q     <= '0;
    end else if (state == ISSUE) begin
      resp_data_q    <= alu_result_i;
      resp_ovf_q     <= alu_overflow_i;
      resp_illegal_q <= alu_op_illegal(op_alu_op);
      resp_tag_q     <= op_tag;
    end
  end

  // The set term looks at the ISSUE cycle so the flag rises together with
  // resp_ovf on RESP entry, and overrides a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   sticky_q <= 1'b0;
    else if (state == ISSUE && alu_overflow_i) sticky_q <= 1'b1;
    else if (ovf_clr)                          sticky_q <= 1'b0;
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.resp_valid   = resp_valid_c;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_ovf     = resp_ovf_q;
  assign bus.resp_illegal = resp_illegal_q;
  assign bus.resp_tag     = resp_tag_q;

  assign alu_rs1_o  = (state != IDLE) ? op_rs1    : '0;
  assign alu_rs2_o  = (state != IDLE) ? op_rs2    : '0;
  assign alu_imm_o  = (state != IDLE) ? op_imm    : '0;
  assign alu_src_o  = (state != IDLE) ? op_src    : 1'b0;
  assign alu_op_o   = (state != IDLE) ? op_alu_op : '0;
  assign ovf_sticky = sticky_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ex_alu_arbiter.sv
module tb_ex_alu_arbiter;
  import ex_alu_arbiter_pkg::*;

  localparam int XLEN = 64;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] alu_rs1_o, alu_rs2_o, alu_imm_o;
  logic            alu_src_o;
  logic [3:0]      alu_op_o;
  logic [XLEN-1:0] alu_result_i;
  logic            alu_overflow_i;
  logic            ovf_sticky;
  logic            ovf_clr;
  logic            busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ex_alu_arbiter_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  ex_alu_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .alu_rs1_o      (alu_rs1_o),
    .alu_rs2_o      (alu_rs2_o),
    .alu_imm_o      (alu_imm_o),
    .alu_src_o      (alu_src_o),
    .alu_op_o       (alu_op_o),
    .alu_result_i   (alu_result_i),
    .alu_overflow_i (alu_overflow_i),
    .ovf_sticky     (ovf_sticky),
    .ovf_clr        (ovf_clr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU stand-in.
  logic [XLEN-1:0] alu_b;
  always_comb begin
    alu_b          = alu_src_o ? alu_imm_o : alu_rs2_o;
    alu_result_i   = '0;
    alu_overflow_i = 1'b0;
    case (alu_op_o)
      ALU_AND:  alu_result_i = alu_rs1_o & alu_b;
      ALU_OR:   alu_result_i = alu_rs1_o | alu_b;
      ALU_ADD: begin
        alu_result_i   = alu_rs1_o + alu_b;
        alu_overflow_i = (alu_rs1_o[63] == alu_b[63]) && (alu_result_i[63] != alu_rs1_o[63]);
      end
      ALU_SUB: begin
        alu_result_i   = alu_rs1_o - alu_b;
        alu_overflow_i = (alu_rs1_o[63] != alu_b[63]) && (alu_result_i[63] != alu_rs1_o[63]);
      end
      ALU_XOR:  alu_result_i = alu_rs1_o ^ alu_b;
      ALU_SLL:  alu_result_i = alu_rs1_o << alu_b[5:0];
      ALU_SRL:  alu_result_i = alu_rs1_o >> alu_b[5:0];
      ALU_SRA:  alu_result_i = $unsigned($signed(alu_rs1_o) >>> alu_b[5:0]);
      ALU_SLT:  alu_result_i = {63'd0, ($signed(alu_rs1_o) < $signed(alu_b))};
      ALU_SLTU: alu_result_i = {63'd0, (alu_rs1_o < alu_b)};
      ALU_SEQ:  alu_result_i = {63'd0, (alu_rs1_o == alu_b)};
      ALU_SNE:  alu_result_i = {63'd0, (alu_rs1_o != alu_b)};
      default:  alu_result_i = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] imm,
                         input logic src, input logic [3:0] tag);
    bus.req_rs1[p*64 +: 64]  = rs1;
    bus.req_rs2[p*64 +: 64]  = rs2;
    bus.req_imm[p*64 +: 64]  = imm;
    bus.req_alu_src[p]       = src;
    bus.req_alu_op[p*4 +: 4] = op;
    bus.req_tag[p*4 +: 4]    = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    rst = 1'b1;
    step();
    vectors++;
    if ({bus.req_ready, bus.resp_valid, busy, ovf_sticky} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.req_ready, bus.resp_valid, busy, ovf_sticky});
    end
    vectors++;
    if ({alu_rs1_o, alu_op_o, bus.resp_data, bus.resp_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: alu_rs1=%h alu_op=%h resp_data=%h resp_tag=%h want 0",
               alu_rs1_o, alu_op_o, bus.resp_data, bus.resp_tag);
    end
    bus.req_valid = 2'b00;
    step();
    rst = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single();
    set_req(0, ALU_ADD, 64'd5, 64'd7, 64'd0, 1'b0, 4'd3);
    bus.resp_ready = 2'b01;
    bus.req_valid  = 2'b01;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    #1;
    vectors++;
    if ({busy, bus.req_ready, alu_op_o} !== {1'b1, 2'b00, ALU_ADD} ||
        alu_rs1_o !== 64'd5 || alu_rs2_o !== 64'd7) begin
      miscompares++;
      $display("FAIL single_issue: busy=%b ready=%b op=%h rs1=%0d rs2=%0d want 1 00 2 5 7",
               busy, bus.req_ready, alu_op_o, alu_rs1_o, alu_rs2_o);
    end
    step();
    vectors++;
    if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'd12 || bus.resp_tag !== 4'd3 ||
        bus.resp_ovf !== 1'b0 || bus.resp_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp: valid=%b data=%0d tag=%0d ovf=%b ill=%b want 01 12 3 0 0",
               bus.resp_valid, bus.resp_data, bus.resp_tag, bus.resp_ovf, bus.resp_illegal);
    end
    step();
    vectors++;
    if (bus.resp_valid !== 2'b00 || busy !== 1'b0 || alu_op_o !== 4'd0) begin
      miscompares++;
      $display("FAIL single_done: valid=%b busy=%b alu_op=%h want 00 0 0", bus.resp_valid, busy, alu_op_o);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_port;
    logic [63:0] exp_data;
    logic [3:0]  exp_tag;
    do_reset();
    set_req(0, ALU_SUB, 64'd10, 64'd4, 64'd0, 1'b0, 4'd1);
    set_req(1, ALU_OR, 64'hF0, 64'h0F, 64'd0, 1'b0, 4'd2);
    bus.resp_ready = 2'b11;
    bus.req_valid  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_port = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (i % 2 == 0) ? 64'd6 : 64'hFF;
      exp_tag  = (i % 2 == 0) ? 4'd1 : 4'd2;
      #1;
      vectors++;
      if (bus.req_ready !== exp_port) begin
        miscompares++;
        $display("FAIL contend_grant%0d: got %b want %b", i, bus.req_ready, exp_port);
      end
      step();
      step();
      vectors++;
      if (bus.resp_valid !== exp_port || bus.resp_data !== exp_data || bus.resp_tag !== exp_tag) begin
        miscompares++;
        $display("FAIL contend_resp%0d: valid=%b data=%h tag=%0d want %b %h %0d",
                 i, bus.resp_valid, bus.resp_data, bus.resp_tag, exp_port, exp_data, exp_tag);
      end
      step();
    end
    bus.req_valid = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    set_req(1, ALU_ADD, 64'd1, 64'd2, 64'd0, 1'b0, 4'd5);
    bus.resp_ready = 2'b00;
    bus.req_valid  = 2'b10;
    step();
    set_req(0, ALU_AND, 64'd6, 64'd3, 64'd0, 1'b0, 4'd7);
    bus.req_valid = 2'b01;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.resp_ready = 2'b01;
      #1;
      vectors++;
      if (bus.resp_valid !== 2'b10 || bus.resp_data !== 64'd3 || bus.resp_tag !== 4'd5 ||
          bus.req_ready !== 2'b00 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b data=%0d tag=%0d ready=%b busy=%b want 10 3 5 00 1",
                 i, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.req_ready, busy);
      end
      step();
    end
    bus.resp_ready = 2'b10;
    step();
    vectors++;
    if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b ready=%b want 00 01", bus.resp_valid, bus.req_ready);
    end
    bus.resp_ready = 2'b01;
    step();
    bus.req_valid = 2'b00;
    step();
    vectors++;
    if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'd2 || bus.resp_tag !== 4'd7) begin
      miscompares++;
      $display("FAIL bp_next: valid=%b data=%0d tag=%0d want 01 2 7", bus.resp_valid, bus.resp_data, bus.resp_tag);
    end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    vectors++;
    if (ovf_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_init: sticky=%b want 0", ovf_sticky);
    end
    set_req(0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd99, 64'd1, 1'b1, 4'd9);
    bus.resp_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = 2'b00;
      if (k == 1) ovf_clr = 1'b1;
      #1;
      vectors++;
      if (alu_src_o !== 1'b1 || alu_imm_o !== 64'd1 || ovf_sticky !== (k == 1)) begin
        miscompares++;
        $display("FAIL ovf_issue%0d: src=%b imm=%0d sticky=%b want 1 1 %0d", k, alu_src_o, alu_imm_o, ovf_sticky, k);
      end
      step();
      ovf_clr = 1'b0;
      vectors++;
      if (bus.resp_ovf !== 1'b1 || ovf_sticky !== 1'b1 || bus.resp_data !== 64'h8000_0000_0000_0000) begin
        miscompares++;
        $display("FAIL ovf_resp%0d: ovf=%b sticky=%b data=%h want 1 1 8000000000000000",
                 k, bus.resp_ovf, ovf_sticky, bus.resp_data);
      end
      step();
    end
    vectors++;
    if (ovf_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_hold: sticky=%b want 1", ovf_sticky);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: sticky=%b want 0", ovf_sticky);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  ops  [2];
    logic [63:0] data [2];
    ops[0] = 4'b1111; data[0] = 64'd0;
    ops[1] = ALU_SNE; data[1] = 64'd1;
    bus.resp_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      set_req(0, ops[k], 64'd3, 64'd4, 64'd0, 1'b0, 4'hA);
      bus.req_valid = 2'b01;
      step();
      bus.req_valid = 2'b00;
      step();
      vectors++;
      if (bus.resp_valid !== 2'b01 || bus.resp_illegal !== (k == 0) ||
          bus.resp_data !== data[k] || bus.resp_ovf !== 1'b0 || bus.resp_tag !== 4'hA) begin
        miscompares++;
        $display("FAIL illegal_resp%0d: valid=%b ill=%b data=%0d ovf=%b tag=%h want 01 %0d %0d 0 a",
                 k, bus.resp_valid, bus.resp_illegal, bus.resp_data, bus.resp_ovf, bus.resp_tag,
                 (k == 0), data[k]);
      end
      step();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_idle%0d: busy=%b want 0", k, busy);
      end
    end
  endtask

  task automatic test_reset_midop();
    set_req(0, ALU_AND, 64'h55, 64'hFF, 64'd0, 1'b0, 4'd1);
    set_req(1, ALU_OR, 64'h1, 64'h2, 64'd0, 1'b0, 4'd2);
    bus.resp_ready = 2'b11;
    bus.req_valid  = 2'b01;
    step();
    bus.req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, bus.resp_valid, bus.req_ready, alu_op_o} !== 9'b0 || alu_rs1_o !== 64'd0 ||
        bus.resp_data !== 64'd0) begin
      miscompares++;
      $display("FAIL midrst_async: busy=%b valid=%b ready=%b op=%h rs1=%h data=%h want all 0",
               busy, bus.resp_valid, bus.req_ready, alu_op_o, alu_rs1_o, bus.resp_data);
    end
    bus.req_valid = 2'b00;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus.resp_valid !== 2'b00 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_quiet%0d: valid=%b busy=%b want 00 0", i, bus.resp_valid, busy);
      end
    end
    bus.req_valid = 2'b11;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_grant: ready=%b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ovf_clr = 1'b0;
    bus.req_valid = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_imm = '0;
    bus.req_alu_src = '0;
    bus.req_alu_op = '0;
    bus.req_tag = '0;
    bus.resp_ready = '0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overflow();
    test_illegal();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_alu_arbiter.md
Name: ex_alu_arbiter

Overview:
- Shares one EX-stage ALU instance (64-bit, 4-bit alu_op encoding 0000..1011) between two requesters.
  - Port 0 is the main pipeline issue.
  - Port 1 is the branch/address unit.
- Round-robin arbitration, valid/ready request handshake, one registered issue cycle, and a held response per requester.
- Keeps a sticky overflow flag for the trap logic.

Parameters:
- XLEN, 64, operand/result width.
- TAGW, 4, requester tag width, returned unchanged with the result.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accept
- req_rs1  in  2*XLEN  rs1 value; port p in bits [p*XLEN +: XLEN]
- req_rs2  in  2*XLEN  rs2 value, same packing
- req_imm  in  2*XLEN  immediate, same packing
- req_alu_src  in  2  1 = use immediate as operand B
- req_alu_op  in  8  4-bit alu_op per port, port p in [p*4 +: 4]
- req_tag  in  2*TAGW  tag per port
- alu_rs1_o  out  XLEN  to ALU rs1_val
- alu_rs2_o  out  XLEN  to ALU rs2_val
- alu_imm_o  out  XLEN  to ALU imm
- alu_src_o  out  1  to ALU alu_src
- alu_op_o  out  4  to ALU alu_op
- alu_result_i  in  XLEN  from ALU alu_result (combinational)
- alu_overflow_i  in  1  from ALU overflow
- resp_valid  out  2  one-hot to the owning port
- resp_ready  in  2  per-port response accept
- resp_data  out  XLEN  captured result
- resp_ovf  out  1  captured overflow
- resp_illegal  out  1  alu_op was > 4'b1011
- resp_tag  out  TAGW  tag of the op
- ovf_sticky  out  1  set by any response with overflow
- ovf_clr  in  1  clears ovf_sticky
- busy  out  1  state != IDLE

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst).
  - All outputs and registers go to 0 and state goes to IDLE.
  - last_grant resets to 1, so port 0 wins the first contention.
- FSM has three states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational, one-hot or zero.
  - If exactly one req_valid is set, that port is readied.
  - If both are set, the port != last_grant is readied.
  - If neither is set, req_ready = 0.
  - On valid&ready, the request's operands, op, src and tag go into the op register; owner and last_grant are updated; next state is ISSUE.
- ISSUE:
  - alu_*_o are driven from the op register. They are held stable whenever state != IDLE and are zero in IDLE.
  - At the end of the cycle, alu_result_i/alu_overflow_i are captured into resp_data/resp_ovf. resp_illegal is taken from the op register; resp_data is whatever the ALU returned (0 for illegal ops).
  - Next state is RESP.
- RESP:
  - resp_valid[owner] = 1. All response fields are held stable until resp_ready[owner] = 1.
  - resp_ready on the non-owner port is ignored.
  - On the handshake, next state is IDLE and resp_valid drops the following cycle.
- Latency and throughput:
  - Accept in cycle N, resp_valid high in N+2.
  - Minimum initiation interval is 3 cycles; req_ready = 0 in ISSUE and RESP.
- A requester must hold its request stable while valid && !ready. The arbiter does not latch un-granted requests.
- ovf_sticky:
  - Set in the cycle RESP is entered with resp_ovf = 1.
  - Cleared by ovf_clr.
  - Set and clear in the same cycle: set wins.
- Reset asserted mid-operation: the in-flight op and response are discarded, with no resp_valid after reset release.
- The ALU is combinational; no ALU state is assumed.

Decomposition:
- Shared package holds:
  - ALU op constants ALU_AND..ALU_SNE (0000..1011) and ALU_OP_MAX = 4'b1011.
  - State encoding IDLE/ISSUE/RESP.
  - NREQ = 2.
- Sub-module rr_arb2: combinational 2-way round-robin picker with inputs req[1:0] and last, output grant[1:0].

Test Plan:
- Single request: port 0 sends ADD (0010), rs1=5, rs2=7, alu_src=0, tag=3, resp_ready=1.
  - Expect: req_ready[0] in cycle 0, resp_valid=2'b01 in cycle 2, resp_data=12, resp_tag=3, resp_ovf=0, back in IDLE in cycle 3.
- Contention after reset: both ports valid, port 0 SUB 10-4, port 1 OR 0xF0|0x0F.
  - Expect: port 0 is granted first with result 6, then port 1 with result 0xFF.
  - With both still valid afterward, the grants alternate 0,1,0,1.
- Backpressure: resp_ready[owner] = 0 for 5 cycles.
  - Expect: resp_valid, resp_data and resp_tag stable throughout, req_ready = 0.
  - Asserting resp_ready on the other port has no effect.
- Overflow: ADD 0x7FFF_FFFF_FFFF_FFFF + 1.
  - Expect: resp_ovf=1, ovf_sticky=1 from RESP onward.
  - ovf_clr pulse in the same cycle as a new overflowing RESP: sticky stays 1.
  - A later lone ovf_clr pulse: sticky goes to 0.
- Illegal op: alu_op = 4'b1111.
  - Expect: resp_illegal=1, resp_data=0, no overflow, FSM returns to IDLE normally.
- Reset mid-op: assert rst during ISSUE.
  - Expect: all outputs 0 immediately (async), no resp_valid after release.
  - A new request is then granted to port 0 first.
